// File: rtl/mem_access_unit.sv
// PC / instruction-register / data-access sequencer for the RISC machine.
// Issues one memory access at a time with a ready handshake and an optional wait-state timeout.
module mem_access_unit #(
  parameter int unsigned          ADDR_W   = 9,
  parameter int unsigned          DATA_W   = 16,
  parameter logic [ADDR_W-1:0]    RESET_PC = '0,
  parameter int unsigned          MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic              load_req,
  input  logic              store_req,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] read_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        m_cmd,
  output logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] mdata,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // Counter only has to reach MAX_WAIT-1; with the timeout disabled it just wraps.
  localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_LOAD  = 2'd2,
    S_STORE = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_daddr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_ir;
  logic [DATA_W-1:0] r_mdata;
  logic [CNT_W-1:0]  r_wait;
  logic              r_done;
  logic              r_err;
  logic              w_timeout;

  assign w_timeout = (MAX_WAIT > 0) && (r_wait == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_daddr <= '0;
      r_wdata <= '0;
      r_ir    <= '0;
      r_mdata <= '0;
      r_wait  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wait <= '0;
          if (pc_load) begin
            r_pc <= pc_in;
          end else if (fetch_req) begin
            r_state <= S_FETCH;
          end else if (load_req) begin
            r_daddr <= addr_in;
            r_state <= S_LOAD;
          end else if (store_req) begin
            r_daddr <= addr_in;
            r_wdata <= wdata_in;
            r_state <= S_STORE;
          end
        end
        default: begin
          if (mem_ready) begin
            if (r_state == S_FETCH) begin
              r_ir <= read_data;
              r_pc <= r_pc + 1'b1;
            end
            if (r_state == S_LOAD) r_mdata <= read_data;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            r_wait  <= '0;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
            r_err   <= 1'b1;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_addr = r_pc;
    m_cmd    = 2'b00;
    case (r_state)
      S_FETCH: m_cmd = 2'b01;
      S_LOAD:  begin mem_addr = r_daddr; m_cmd = 2'b01; end
      S_STORE: begin mem_addr = r_daddr; m_cmd = 2'b10; end
      default: ;
    endcase
  end

  assign write_data = r_wdata;
  assign ir         = r_ir;
  assign mdata      = r_mdata;
  assign pc         = r_pc;
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign err        = r_err;

endmodule
